// File: rtl/hex_display_scanner_if.sv
// Display scanner bus: capture/halt/blank controls in, scanned digit drive out.
interface hex_display_scanner_if;
  logic        Load;
  logic [31:0] Value;
  logic        Halt;
  logic        Blank;
  logic [7:0]  An;
  logic [6:0]  Seg;
  logic        Dp;
  logic [31:0] Shown;

  // Driver side: the syscall decoder / CPU that feeds the display
  modport master (
    output Load, Value, Halt, Blank,
    input  An, Seg, Dp, Shown
  );

  // Display side: the scanner itself
  modport slave (
    input  Load, Value, Halt, Blank,
    output An, Seg, Dp, Shown
  );
endinterface

// File: rtl/hex_display_scanner.sv
// Eight-digit multiplexed hex display driver with leading-zero blanking
// and a halt indicator that blinks the whole display once the CPU stops.
module hex_display_scanner #(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_SCANS = 32
) (
  input logic clk,
  input logic rst,
  hex_display_scanner_if.slave bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SCANS - 1);

  typedef enum logic {BLINK_ON, BLINK_OFF} blink_state_e;

  logic [31:0]   shown_q, shown_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic          halt_q, halt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  blink_state_e  blink_state_q, blink_state_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          presc_tc;
  logic          scan_wrap;
  logic          blink_period_done;
  logic          blink_on;
  logic [3:0]    nibble;
  logic [31:0]   upper;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Scan timing events: end of a digit slot, end of a full scan, end of a blink phase
  always_comb begin
    presc_tc          = (presc_q == PRESC_LAST);
    scan_wrap         = presc_tc && (idx_q == 3'd7);
    blink_period_done = halt_q && scan_wrap && (blink_cnt_q == BLINK_LAST);
  end

  // Next state of the latched word, scan position, sticky halt and scan counter
  always_comb begin
    shown_d     = bus.Load ? bus.Value : shown_q;
    presc_d     = presc_tc ? '0 : presc_q + PW'(1);
    idx_d       = presc_tc ? idx_q + 3'd1 : idx_q;
    halt_d      = halt_q | bus.Halt;
    blink_cnt_d = blink_cnt_q;
    if (halt_q && scan_wrap) begin
      blink_cnt_d = blink_period_done ? '0 : blink_cnt_q + BW'(1);
    end
  end

  // Datapath registers; reset drops any scan in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shown_q     <= '0;
      presc_q     <= '0;
      idx_q       <= '0;
      halt_q      <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      shown_q     <= shown_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      halt_q      <= halt_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  // Blink phase state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_state_q <= BLINK_ON;
    end else begin
      blink_state_q <= blink_state_d;
    end
  end

  // Blink phase flips after each run of BLINK_SCANS completed scans while halted
  always_comb begin
    blink_state_d = blink_state_q;
    if (blink_period_done) begin
      blink_state_d = (blink_state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
    end
  end

  // Blink phase output: display lit only in the on phase
  always_comb begin
    blink_on = (blink_state_q == BLINK_ON);
  end

  // Compose the drive for the currently selected digit
  always_comb begin
    nibble = shown_q[{idx_q, 2'b00} +: 4];
    upper  = shown_q >> {idx_q, 2'b00};
    an_d   = ~(8'b1 << idx_q);
    seg_d  = hex_to_seg(nibble);
    dp_d   = !(halt_q && (idx_q == 3'd0));
    if (bus.Blank && (idx_q != 3'd0) && (upper == 32'd0)) begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
    end
    if (!blink_on) begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  // Registered display pins so the LED drive is glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= 8'hFF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign bus.An    = an_q;
  assign bus.Seg   = seg_q;
  assign bus.Dp    = dp_q;
  assign bus.Shown = shown_q;

endmodule

// File: doc/hex_display_scanner.md
HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles each digit is shown (legal range >= 1).
REQ-002 SHALL have parameter BLINK_SCANS, default 32, meaning full 8-digit scans per blink phase while halted (legal range >= 1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port Load, input, 1 bit: capture strobe for Value, driven by the syscall decoder's print enable.
REQ-006 SHALL have port Value, input, 32 bits: word to display, driven by the decoder's Hex output.
REQ-007 SHALL have port Halt, input, 1 bit: CPU halt indication.
REQ-008 SHALL have port Blank, input, 1 bit: leading-zero suppression enable.
REQ-009 SHALL have port An, output, 8 bits: active-low digit enables; bit i is digit i, where digit 0 is the least significant nibble.
REQ-010 SHALL have port Seg, output, 7 bits: active-low segments, order {g,f,e,d,c,b,a}.
REQ-011 SHALL have port Dp, output, 1 bit: active-low decimal point.
REQ-012 SHALL have port Shown, output, 32 bits: currently latched display word.

Function
REQ-013 SHALL load Shown <= Value on each rising edge where Load=1; Shown SHALL otherwise hold.
REQ-014 SHALL keep a prescaler counting 0..SCAN_DIV-1; at terminal count it wraps to 0 and the digit index (0..7) increments; index 7 wraps to 0.
REQ-015 SHALL advance the digit index on every cycle when SCAN_DIV=1.
REQ-016 SHALL register An, Seg and Dp; they reflect the index, Shown and the flags as sampled on the previous edge (one-cycle latency).
REQ-017 SHALL display a Load on Seg no later than 2 edges after Load, provided the selected digit's nibble changed.
REQ-018 SHALL drive the selected digit i as An = ~(8'b1 << i) and Seg = decode(Shown[4i+3:4i]).
REQ-019 SHALL decode hex 0..F to Seg = 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
REQ-020 SHALL blank digit i (An=8'hFF, Seg=7'h7F) when Blank=1, i>0 and Shown[31:4i]==0; digit 0 is never suppressed.
REQ-021 SHALL set a sticky halt latch on any edge with Halt=1; only rst clears it.
REQ-022 SHALL, while the halt latch is 0, hold Dp=1 and the blink phase at on.
REQ-023 SHALL, while the halt latch is 1, drive Dp=0 whenever digit 0 is selected and Dp=1 otherwise.
REQ-024 SHALL, while the halt latch is 1, count completed scans (index wrap 7->0) and toggle the blink phase every BLINK_SCANS scans.
REQ-025 SHALL force An=8'hFF, Seg=7'h7F and Dp=1 while the blink phase is off.
REQ-026 SHALL apply the load and the scan together when Load and the prescaler terminal count coincide: the new digit shows the new Shown on the next registered update.
REQ-027 SHALL take Halt and Load in the same cycle: both take effect, and the loaded value remains visible in blink-on phases.

Reset
REQ-028 SHALL, while rst=1 (asynchronously), force Shown=0, prescaler=0, index=0, halt latch=0, blink counter=0, blink phase on, An=8'hFF, Seg=7'h7F, Dp=1.
REQ-029 SHALL ignore Load and Halt while rst=1.
REQ-030 SHALL drive An=8'hFE, Seg=7'h40 on the first edge after rst deasserts.
REQ-031 SHALL abandon the scan and blink state when rst asserts mid-scan or mid-blink; no partial state survives.

Verification (SCAN_DIV=2, BLINK_SCANS=2)
REQ-032 SHALL cover: reset release, Blank=0 -> An walks FE,FD,...,7F, changing every 2 cycles with Seg=7'h40 throughout, then wraps to FE.
REQ-033 SHALL cover: Load with Value=32'h1234ABCD -> digits 0..7 show Seg 21,46,03,08,19,30,24,79; Shown=32'h1234ABCD.
REQ-034 SHALL cover: Value=32'h000000A5, Blank=1 -> digit 0 Seg=12, digit 1 Seg=08, digits 2..7 An=8'hFF; with Blank=0 -> digits 2..7 Seg=40.
REQ-035 SHALL cover: 1-cycle Halt pulse -> Dp=0 only when An=8'hFE, then the display is dark (An=8'hFF) for 2 full scans (32 cycles), then on for 2, repeating; Halt deasserting has no effect.
REQ-036 SHALL cover: rst asserted mid-blink-off while the latch is set -> An=8'hFF and Dp=1 immediately; after release, normal undimmed scan with Dp=1.
REQ-037 SHALL cover: Load asserted on a prescaler terminal-count edge -> the next digit shows the new nibble on the following edge.
